window_3x3_generator: RTL and testbench

//  Streaming 3x3 neighbourhood former; sits directly upstream of the median/switching stages.
//  - Accepts one raster-order pixel per cycle.
//  - Buffers the two previous rows.
//  - Emits the nine window pixels X0..X8 plus a window-valid strobe.
//  - X0..X8 feed the median sorter and the switching stage in parallel.

---
 rtl/filter_pkg.sv | 14 +
 rtl/window_3x3_generator_if.sv | 26 ++
 rtl/window_3x3_generator_line_buffer.sv | 29 ++
 rtl/window_3x3_generator.sv | 107 ++++++++++
 tb/tb_window_3x3_generator.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared types for the 3x3 filter datapath.
//   DW       : default pixel width in bits
//   pixel_t  : one pixel
//   window_t : nine pixels, row-major, index 0 top-left .. 8 bottom-right
//   WIN_N    : number of pixels in a window
package filter_pkg;

   localparam int DW    = 8;
   localparam int WIN_N = 9;

   typedef logic [DW-1:0] pixel_t;
   typedef pixel_t        window_t [0:WIN_N-1];

endpackage

// File: rtl/window_3x3_generator_if.sv
// Pixel-stream in / window out bundle for window_3x3_generator.
//   Pix_In, Pix_Valid, Frame_Start : raster pixel stream into the former
//   X0..X8                         : 3x3 window, row-major (X4 = centre)
//   Win_Valid                      : one-cycle strobe per complete window
//   Frame_Done                     : one-cycle strobe after the last pixel of a frame
// master = pixel source / window consumer, slave = the window former.
interface window_3x3_generator_if #(
   parameter int DW = 8
);
   logic [DW-1:0] Pix_In;
   logic          Pix_Valid;
   logic          Frame_Start;
   logic [DW-1:0] X0, X1, X2, X3, X4, X5, X6, X7, X8;
   logic          Win_Valid;
   logic          Frame_Done;

   modport master (
      output Pix_In, Pix_Valid, Frame_Start,
      input  X0, X1, X2, X3, X4, X5, X6, X7, X8, Win_Valid, Frame_Done
   );

   modport slave (
      input  Pix_In, Pix_Valid, Frame_Start,
      output X0, X1, X2, X3, X4, X5, X6, X7, X8, Win_Valid, Frame_Done
   );
endinterface

// File: rtl/window_3x3_generator_line_buffer.sv
// line_buffer: single-row circular buffer addressed by column.
//   Clk  : write clock
//   addr : column address (read and write share it)
//   we   : write enable
//   din  : pixel written at addr
//   dout : combinational read of addr; returns the old value in the cycle
//          it is overwritten (read-before-write)
// The array is deliberately not reset; the frame counters upstream keep
// stale contents out of every emitted window.
module line_buffer #(
   parameter int DEPTH = 256,
   parameter int DW    = 8
) (
   input  logic                     Clk,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic                     we,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout
);

   logic [DW-1:0] mem [0:DEPTH-1];

   always_ff @(posedge Clk) begin
      if (we) mem[addr] <= din;
   end

   assign dout = mem[addr];

endmodule

// File: rtl/window_3x3_generator.sv
// window_3x3_generator: streaming 3x3 neighbourhood former.
//   Clk : rising-edge clock
//   Rst : asynchronous, active-low reset
//   s   : slave side of window_3x3_generator_if
//         (pixel stream in, X0..X8 / Win_Valid / Frame_Done out)
// Two line buffers hold the previous two rows; a 3x3 register array shifts
// left on every accepted pixel, loading {row-2, row-1, current} on the right.
module window_3x3_generator #(
   parameter int DW         = filter_pkg::DW,
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256
) (
   input logic                    Clk,
   input logic                    Rst,
   window_3x3_generator_if.slave  s
);
   import filter_pkg::*;

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          accept;
   logic [DW-1:0] lb0_dout;
   logic [DW-1:0] lb1_dout;
   logic [DW-1:0] win [0:WIN_N-1];

   assign accept = s.Pix_Valid;

   // Frame_Start re-labels the accepted pixel as (0,0) regardless of the counters.
   assign cur_col = (accept && s.Frame_Start) ? '0 : col;
   assign cur_row = (accept && s.Frame_Start) ? '0 : row;

   // LB0 holds the previous row, LB1 the one before; LB0's old value ages into LB1.
   line_buffer #(.DEPTH(IMG_WIDTH), .DW(DW)) u_lb0 (
      .Clk  (Clk),
      .addr (cur_col),
      .we   (accept),
      .din  (s.Pix_In),
      .dout (lb0_dout)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .DW(DW)) u_lb1 (
      .Clk  (Clk),
      .addr (cur_col),
      .we   (accept),
      .din  (lb0_dout),
      .dout (lb1_dout)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (cur_col == CW'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < WIN_N; i++) win[i] <= '0;
      end else if (accept) begin
         win[0] <= win[1];
         win[1] <= win[2];
         win[2] <= lb1_dout;
         win[3] <= win[4];
         win[4] <= win[5];
         win[5] <= lb0_dout;
         win[6] <= win[7];
         win[7] <= win[8];
         win[8] <= s.Pix_In;
      end
   end

   // c>=2 keeps windows from straddling the row wrap; r>=2 from straddling the frame start.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s.Win_Valid  <= 1'b0;
         s.Frame_Done <= 1'b0;
      end else begin
         s.Win_Valid  <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
         s.Frame_Done <= accept && (cur_row == RW'(IMG_HEIGHT - 1))
                                && (cur_col == CW'(IMG_WIDTH - 1));
      end
   end

   assign s.X0 = win[0];
   assign s.X1 = win[1];
   assign s.X2 = win[2];
   assign s.X3 = win[3];
   assign s.X4 = win[4];
   assign s.X5 = win[5];
   assign s.X6 = win[6];
   assign s.X7 = win[7];
   assign s.X8 = win[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
module tb_window_3x3_generator;

   localparam int W = 5;
   localparam int H = 5;
   localparam int BW = 256;
   localparam int BH = 256;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   window_3x3_generator_if #(.DW(8)) ifa ();
   window_3x3_generator_if #(.DW(8)) ifb ();

   window_3x3_generator #(.DW(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_a (
      .Clk (clk),
      .Rst (rst_n),
      .s   (ifa.slave)
   );

   window_3x3_generator #(.DW(8), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
      .Clk (clk),
      .Rst (rst_n),
      .s   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- capture of emitted windows ----------------
   logic [71:0] qa[$];
   logic [71:0] qb[$];
   int          fd_cnt_a, fd_pos_a, fd_cnt_b, fd_pos_b;
   logic        fd_wv_a, fd_wv_b;

   function automatic logic [71:0] pack_a();
      return {ifa.X0, ifa.X1, ifa.X2, ifa.X3, ifa.X4, ifa.X5, ifa.X6, ifa.X7, ifa.X8};
   endfunction

   function automatic logic [71:0] pack_b();
      return {ifb.X0, ifb.X1, ifb.X2, ifb.X3, ifb.X4, ifb.X5, ifb.X6, ifb.X7, ifb.X8};
   endfunction

   always @(negedge clk) begin
      if (ifa.Win_Valid === 1'b1) qa.push_back(pack_a());
      if (ifa.Frame_Done === 1'b1) begin
         fd_cnt_a++;
         fd_pos_a = qa.size();
         fd_wv_a  = ifa.Win_Valid;
      end
      if (ifb.Win_Valid === 1'b1) qb.push_back(pack_b());
      if (ifb.Frame_Done === 1'b1) begin
         fd_cnt_b++;
         fd_pos_b = qb.size();
         fd_wv_b  = ifb.Win_Valid;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] p5(int r, int c, logic [7:0] base);
      return base + 8'(r * 16 + c);
   endfunction

   function automatic logic [7:0] pb(int r, int c);
      return 8'(r * 3 + c);
   endfunction

   // Window centred at (r,c) of a 5x5 frame, packed X0 (MSB) .. X8 (LSB).
   function automatic logic [71:0] exp5(int r, int c, logic [7:0] base);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[63:0], p5(r - 1 + i, c - 1 + j, base)};
      return w;
   endfunction

   function automatic logic [71:0] expb(int r, int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[63:0], pb(r - 1 + i, c - 1 + j)};
      return w;
   endfunction

   // All windows of one 5x5 frame in raster order of their centres.
   task automatic build_exp(input logic [7:0] base, inout logic [71:0] q[$]);
      for (int r = 1; r <= H - 2; r++)
         for (int c = 1; c <= W - 2; c++)
            q.push_back(exp5(r, c, base));
   endtask

   // ---------------- drivers ----------------
   task automatic send_a(input logic v, input logic fs, input logic [7:0] pix);
      @(posedge clk);
      #1;
      ifa.Pix_Valid   = v;
      ifa.Frame_Start = fs;
      ifa.Pix_In      = pix;
      @(negedge clk);
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) send_a(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame_a(input logic [7:0] base, input logic fs_first);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send_a(1'b1, fs_first && r == 0 && c == 0, p5(r, c, base));
   endtask

   task automatic clear_a();
      qa.delete();
      fd_cnt_a = 0;
      fd_pos_a = -1;
      fd_wv_a  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (pack_a() !== 72'h0 || ifa.Win_Valid !== 1'b0 || ifa.Frame_Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got X=%h wv=%b fd=%b, need all 0",
                  pack_a(), ifa.Win_Valid, ifa.Frame_Done);
      end
      checks++;
      if (pack_b() !== 72'h0 || ifb.Win_Valid !== 1'b0 || ifb.Frame_Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs_b: got X=%h wv=%b fd=%b, need all 0",
                  pack_b(), ifb.Win_Valid, ifb.Frame_Done);
      end
   endtask

   task automatic test_continuous();
      logic [71:0] exp_q[$];
      clear_a();
      build_exp(8'h00, exp_q);
      send_frame_a(8'h00, 1'b0);
      idle_a(3);
      checks++;
      if (qa.size() != 9) begin
         errors++;
         $display("FAIL cont_count: got %0d windows, need 9", qa.size());
      end
      for (int k = 0; k < 9 && k < qa.size(); k++) begin
         checks++;
         if (qa[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL cont_win%0d: got %h, need %h", k, qa[k], exp_q[k]);
         end
      end
      if (qa.size() == 9) begin
         checks++;
         if (qa[0] !== 72'h00_01_02_10_11_12_20_21_22) begin
            errors++;
            $display("FAIL cont_first: got %h, need 000102101112202122", qa[0]);
         end
         checks++;
         if (qa[8][39:32] !== 8'h33 || qa[8][7:0] !== 8'h44) begin
            errors++;
            $display("FAIL cont_last: got X4=%h X8=%h, need 33 44", qa[8][39:32], qa[8][7:0]);
         end
      end
      checks++;
      if (fd_cnt_a != 1 || fd_pos_a != 9 || fd_wv_a !== 1'b1) begin
         errors++;
         $display("FAIL cont_frame_done: got count=%0d pos=%0d wv=%b, need 1 9 1",
                  fd_cnt_a, fd_pos_a, fd_wv_a);
      end
   endtask

   task automatic test_gaps();
      logic [71:0] exp_q[$];
      logic [71:0] snap;
      logic        last_idle;
      int          stall_bad;
      clear_a();
      build_exp(8'h00, exp_q);
      snap      = pack_a();
      last_idle = 1'b0;
      stall_bad = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            while ($urandom_range(0, 2) == 0) begin
               send_a(1'b0, 1'b0, 8'($urandom));
               if (last_idle && (pack_a() !== snap || ifa.Win_Valid !== 1'b0)) stall_bad++;
               snap      = pack_a();
               last_idle = 1'b1;
            end
            send_a(1'b1, 1'b0, p5(r, c, 8'h00));
            if (last_idle && (pack_a() !== snap || ifa.Win_Valid !== 1'b0)) stall_bad++;
            snap      = pack_a();
            last_idle = 1'b0;
         end
      end
      idle_a(3);
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL gap_stable: got %0d cycles changing during stalls, need 0", stall_bad);
      end
      checks++;
      if (qa.size() != 9) begin
         errors++;
         $display("FAIL gap_count: got %0d windows, need 9", qa.size());
      end
      for (int k = 0; k < 9 && k < qa.size(); k++) begin
         checks++;
         if (qa[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL gap_win%0d: got %h, need %h", k, qa[k], exp_q[k]);
         end
      end
      checks++;
      if (fd_cnt_a != 1 || fd_pos_a != 9) begin
         errors++;
         $display("FAIL gap_frame_done: got count=%0d pos=%0d, need 1 9", fd_cnt_a, fd_pos_a);
      end
   endtask

   task automatic test_frame_start_abort();
      logic [71:0] exp_q[$];
      clear_a();
      build_exp(8'h00, exp_q);
      // Seven junk pixels fill the line buffers with data that must never surface.
      for (int i = 0; i < 7; i++) send_a(1'b1, 1'b0, 8'($urandom));
      // Frame_Start without Pix_Valid must be ignored.
      send_a(1'b0, 1'b1, 8'hEE);
      send_frame_a(8'h00, 1'b1);
      idle_a(3);
      checks++;
      if (qa.size() != 9) begin
         errors++;
         $display("FAIL abort_count: got %0d windows, need 9", qa.size());
      end
      for (int k = 0; k < 9 && k < qa.size(); k++) begin
         checks++;
         if (qa[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL abort_win%0d: got %h, need %h", k, qa[k], exp_q[k]);
         end
      end
      checks++;
      if (fd_cnt_a != 1) begin
         errors++;
         $display("FAIL abort_frame_done: got count=%0d, need 1", fd_cnt_a);
      end
   endtask

   task automatic test_mid_reset();
      logic [71:0] exp_q[$];
      clear_a();
      build_exp(8'h00, exp_q);
      for (int i = 0; i < 13; i++) send_a(1'b1, 1'b0, p5(i / W, i % W, 8'h00));
      @(posedge clk);
      #1;
      ifa.Pix_Valid = 1'b0;
      rst_n         = 1'b0;
      #1;
      checks++;
      if (pack_a() !== 72'h0 || ifa.Win_Valid !== 1'b0 || ifa.Frame_Done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: got X=%h wv=%b fd=%b, need all 0",
                  pack_a(), ifa.Win_Valid, ifa.Frame_Done);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_a();
      send_frame_a(8'h00, 1'b0);
      idle_a(3);
      checks++;
      if (qa.size() != 9) begin
         errors++;
         $display("FAIL midrst_count: got %0d windows, need 9", qa.size());
      end
      for (int k = 0; k < 9 && k < qa.size(); k++) begin
         checks++;
         if (qa[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL midrst_win%0d: got %h, need %h", k, qa[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [71:0] exp_q[$];
      clear_a();
      build_exp(8'h00, exp_q);
      build_exp(8'h80, exp_q);
      send_frame_a(8'h00, 1'b0);
      send_frame_a(8'h80, 1'b0);
      idle_a(3);
      checks++;
      if (qa.size() != 18) begin
         errors++;
         $display("FAIL b2b_count: got %0d windows, need 18", qa.size());
      end
      for (int k = 0; k < 18 && k < qa.size(); k++) begin
         checks++;
         if (qa[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL b2b_win%0d: got %h, need %h", k, qa[k], exp_q[k]);
         end
      end
      if (qa.size() == 18) begin
         checks++;
         if (qa[9][71:64] !== 8'h80 || qa[9][7:0] !== 8'hA2) begin
            errors++;
            $display("FAIL b2b_f2_first: got X0=%h X8=%h, need 80 A2", qa[9][71:64], qa[9][7:0]);
         end
      end
      checks++;
      if (fd_cnt_a != 2 || fd_pos_a != 18) begin
         errors++;
         $display("FAIL b2b_frame_done: got count=%0d pos=%0d, need 2 18", fd_cnt_a, fd_pos_a);
      end
   endtask

   task automatic test_wide_smoke();
      int k;
      int bad;
      qb.delete();
      fd_cnt_b = 0;
      fd_pos_b = -1;
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BW; c++) begin
            @(posedge clk);
            #1;
            ifb.Pix_Valid   = 1'b1;
            ifb.Frame_Start = 1'b0;
            ifb.Pix_In      = pb(r, c);
         end
      end
      @(posedge clk);
      #1;
      ifb.Pix_Valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (qb.size() != (BH - 2) * (BW - 2)) begin
         errors++;
         $display("FAIL wide_count: got %0d windows, need %0d", qb.size(), (BH - 2) * (BW - 2));
      end
      k   = 0;
      bad = 0;
      for (int r = 1; r <= BH - 2; r++) begin
         for (int c = 1; c <= BW - 2; c++) begin
            if (k < qb.size()) begin
               checks++;
               if (qb[k][39:32] !== pb(r, c) || qb[k] !== expb(r, c)) begin
                  errors++;
                  if (bad < 5)
                     $display("FAIL wide_win(%0d,%0d): got %h, need %h", r, c, qb[k], expb(r, c));
                  bad++;
               end
            end
            k++;
         end
      end
      checks++;
      if (fd_cnt_b != 1 || fd_pos_b != (BH - 2) * (BW - 2) || fd_wv_b !== 1'b1) begin
         errors++;
         $display("FAIL wide_frame_done: got count=%0d pos=%0d wv=%b, need 1 %0d 1",
                  fd_cnt_b, fd_pos_b, fd_wv_b, (BH - 2) * (BW - 2));
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      fd_cnt_a        = 0;
      fd_cnt_b        = 0;
      fd_pos_a        = -1;
      fd_pos_b        = -1;
      fd_wv_a         = 1'b0;
      fd_wv_b         = 1'b0;
      rst_n           = 1'b0;
      ifa.Pix_In      = '0;
      ifa.Pix_Valid   = 1'b0;
      ifa.Frame_Start = 1'b0;
      ifb.Pix_In      = '0;
      ifb.Pix_Valid   = 1'b0;
      ifb.Frame_Start = 1'b0;
      #12;
      test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_continuous();
      test_gaps();
      test_frame_start_abort();
      test_mid_reset();
      test_back_to_back();
      test_wide_smoke();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
